axis_gate_decision_ctrl: RTL and testbench

Per-packet decision sequencer for the 250 MHz box packet gate.
- Buffers allow/drop verdicts from the upstream classifier in a small FIFO.
- Tracks packet boundaries by tapping the gate's input handshake, and presents exactly one verdict per packet start.
- Substitutes a default verdict when the classifier is late.
- Supports a bring-up bypass and a flush.

---
 rtl/gate_ctrl_pkg.sv | 21 ++
 rtl/gate_decision_fifo.sv | 71 +++++++
 rtl/axis_gate_decision_ctrl.sv | 166 ++++++++++++++++
 tb/tb_axis_gate_decision_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// gate_ctrl_pkg
// Shared types and constants for the packet gate decision sequencer.
//   state_t      : packet-position state (between packets / inside a packet)
//   CNT_W        : width of the statistics counters
//   level_width  : number of bits needed to hold a FIFO occupancy of 0..depth
// -----------------------------------------------------------------------------
package gate_ctrl_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [0:0] {
        SOP_WAIT = 1'b0,
        IN_PKT   = 1'b1
    } state_t;

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/gate_decision_fifo.sv
// -----------------------------------------------------------------------------
// gate_decision_fifo
// 1-bit-wide synchronous FIFO holding allow/drop verdicts.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   push, din    : write request and verdict bit (ignored when full)
//   pop          : read request (ignored when empty)
//   flush        : discard all entries; wins over push and pop
//   dout         : verdict at the head of the FIFO (valid when !empty)
//   full, empty  : occupancy flags
//   level        : current number of entries (0..DEPTH)
// -----------------------------------------------------------------------------
module gate_decision_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic                         din,
    output logic                         dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the address bits coincide.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [DEPTH-1:0] mem;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/axis_gate_decision_ctrl.sv
// -----------------------------------------------------------------------------
// axis_gate_decision_ctrl
// Per-packet decision sequencer for the packet gate. Verdicts from the
// classifier are queued; the gate's input handshake is tapped to find packet
// starts, and exactly one verdict is presented per start of packet. A default
// verdict is substituted when the classifier is late; a bypass forces allow.
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   cls_valid, cls_allow, cls_ready  : classifier verdict handshake
//   mon_tvalid, mon_tready, mon_tlast: tap of the gate's input stream
//   decision_valid, decision_allow   : verdict presented to the gate
//   cfg_bypass                       : present allow without popping the FIFO
//   cfg_flush                        : pulse; empties FIFO, clears timeout
//   fifo_level                       : FIFO occupancy
//   cnt_used, cnt_timeout            : FIFO verdicts consumed / defaults issued
//   err_underrun                     : sticky; start beat taken with no verdict
// -----------------------------------------------------------------------------
module axis_gate_decision_ctrl
    import gate_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter bit DEFAULT_ALLOW  = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cls_valid,
    input  logic                              cls_allow,
    output logic                              cls_ready,
    input  logic                              mon_tvalid,
    input  logic                              mon_tready,
    input  logic                              mon_tlast,
    output logic                              decision_valid,
    output logic                              decision_allow,
    input  logic                              cfg_bypass,
    input  logic                              cfg_flush,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic [CNT_W-1:0]                  cnt_used,
    output logic [CNT_W-1:0]                  cnt_timeout,
    output logic                              err_underrun
);

    localparam int                LVL_W    = level_width(FIFO_DEPTH);
    localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t             state;
    logic               bypass_q;
    logic               tmo_fired;
    logic [TMO_W-1:0]   tmo_cnt;

    logic               beat;
    logic               sop;
    logic               src_bypass;
    logic               src_tmo;
    logic               src_fifo;
    logic               tmo_run;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic [LVL_W-1:0]   fifo_level_i;

    gate_decision_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (cfg_flush),
        .din   (cls_allow),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level_i)
    );

    assign fifo_level = fifo_level_i;

    assign beat      = mon_tvalid & mon_tready;
    assign sop       = (state == SOP_WAIT);
    assign cls_ready = ~fifo_full & ~rst;
    assign fifo_push = cls_valid & cls_ready;

    // Verdict source selection. Everything here is registered state, so the
    // gate sees no combinational path from any input. A fired timeout outranks
    // the FIFO: once the default is on offer it belongs to this packet, and a
    // late classifier verdict waits in the FIFO for the following packet.
    assign src_bypass = sop & bypass_q;
    assign src_tmo    = sop & ~bypass_q & tmo_fired;
    assign src_fifo   = sop & ~bypass_q & ~tmo_fired & ~fifo_empty;

    assign decision_valid = src_bypass | src_tmo | src_fifo;
    assign decision_allow = src_bypass | (src_tmo & DEFAULT_ALLOW) |
                            (src_fifo & fifo_dout);

    assign fifo_pop = beat & src_fifo;

    // The timeout only runs while a packet start is actually waiting on the
    // classifier: traffic offered, nothing queued and nothing else on offer.
    assign tmo_run = sop & mon_tvalid & fifo_empty & ~bypass_q & ~tmo_fired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SOP_WAIT;
        end else if (beat) begin
            if (sop && !mon_tlast) begin
                state <= IN_PKT;
            end else if (!sop && mon_tlast) begin
                state <= SOP_WAIT;
            end
        end
    end

    // Registered so the decision outputs stay free of input paths; a change
    // made mid-packet is simply seen at the next start of packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bypass_q <= 1'b0;
        end else begin
            bypass_q <= cfg_bypass;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt     <= '0;
            tmo_fired   <= 1'b0;
            cnt_timeout <= '0;
        end else if (cfg_flush) begin
            tmo_cnt   <= '0;
            tmo_fired <= 1'b0;
        end else if (tmo_run) begin
            if (tmo_cnt == TMO_LAST) begin
                tmo_cnt     <= '0;
                tmo_fired   <= 1'b1;
                cnt_timeout <= cnt_timeout + 1'b1;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end else begin
            tmo_cnt <= '0;
            if (beat && src_tmo) begin
                tmo_fired <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_used     <= '0;
            err_underrun <= 1'b0;
        end else begin
            if (fifo_pop) begin
                cnt_used <= cnt_used + 1'b1;
            end
            if (beat && sop && !decision_valid) begin
                err_underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_gate_decision_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axis_gate_decision_ctrl
// Directed, self-checking bench for axis_gate_decision_ctrl. Verdicts driven
// into the classifier port are pushed onto a scoreboard queue and popped when
// a start-of-packet beat consumes them.
// -----------------------------------------------------------------------------
module tb_axis_gate_decision_ctrl;

    localparam int DEPTH     = 8;
    localparam int TMO       = 16;
    localparam bit DEF_ALLOW = 1'b0;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        cls_valid  = 1'b0;
    logic        cls_allow  = 1'b0;
    logic        mon_tvalid = 1'b0;
    logic        mon_tready = 1'b0;
    logic        mon_tlast  = 1'b0;
    logic        cfg_bypass = 1'b0;
    logic        cfg_flush  = 1'b0;
    logic        cls_ready;
    logic        decision_valid;
    logic        decision_allow;
    logic        err_underrun;
    logic [3:0]  fifo_level;
    logic [31:0] cnt_used;
    logic [31:0] cnt_timeout;

    // Scoreboard and reference state.
    bit    exp_q[$];
    bit    in_pkt;
    bit    fired_m;
    bit    byp_m;
    bit    underrun_m;
    int    used_m;
    int    tmo_m;
    int    tests_run;
    int    tests_failed;
    string step;

    axis_gate_decision_ctrl #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .DEFAULT_ALLOW  (DEF_ALLOW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cls_valid      (cls_valid),
        .cls_allow      (cls_allow),
        .cls_ready      (cls_ready),
        .mon_tvalid     (mon_tvalid),
        .mon_tready     (mon_tready),
        .mon_tlast      (mon_tlast),
        .decision_valid (decision_valid),
        .decision_allow (decision_allow),
        .cfg_bypass     (cfg_bypass),
        .cfg_flush      (cfg_flush),
        .fifo_level     (fifo_level),
        .cnt_used       (cnt_used),
        .cnt_timeout    (cnt_timeout),
        .err_underrun   (err_underrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s/%s: observed %0h expected %0h", step, tag, obs, exp);
        end
    endtask

    // Compare every observable output against the reference state.
    task automatic checkModel();
        bit exp_v;
        bit exp_a;
        checkOutput("fifo_level", 32'(fifo_level), exp_q.size());
        checkOutput("cls_ready", 32'(cls_ready), 32'(exp_q.size() < DEPTH));
        checkOutput("cnt_used", cnt_used, used_m);
        checkOutput("cnt_timeout", cnt_timeout, tmo_m);
        checkOutput("err_underrun", 32'(err_underrun), 32'(underrun_m));
        exp_v = !in_pkt && (byp_m || fired_m || exp_q.size() != 0);
        checkOutput("decision_valid", 32'(decision_valid), 32'(exp_v));
        if (exp_v) begin
            if (byp_m)        exp_a = 1'b1;
            else if (fired_m) exp_a = DEF_ALLOW;
            else              exp_a = exp_q[0];
            checkOutput("decision_allow", 32'(decision_allow), 32'(exp_a));
        end
    endtask

    // One clock cycle: drive inputs, check the current state, clock, and
    // advance the reference.
    task automatic applyStimulus(input bit cv, input bit ca, input bit tv,
                                 input bit tr, input bit tl, input bit fl);
        bit push;
        bit beat;
        cls_valid  = cv;
        cls_allow  = ca;
        mon_tvalid = tv;
        mon_tready = tr;
        mon_tlast  = tl;
        cfg_flush  = fl;
        #1;
        checkModel();
        push = cv && (exp_q.size() < DEPTH);
        beat = tv && tr;
        @(posedge clk);
        #1;
        if (beat) begin
            if (!in_pkt) begin
                if (byp_m) begin
                end else if (fired_m) begin
                    fired_m = 1'b0;
                end else if (exp_q.size() != 0) begin
                    exp_q.delete(0);
                    used_m++;
                end else begin
                    underrun_m = 1'b1;
                end
                in_pkt = !tl;
            end else if (tl) begin
                in_pkt = 1'b0;
            end
        end
        if (push) exp_q.push_back(ca);
        if (fl) begin
            exp_q.delete();
            fired_m = 1'b0;
        end
        byp_m = cfg_bypass;
    endtask

    task automatic resetModel();
        exp_q.delete();
        in_pkt     = 1'b0;
        fired_m    = 1'b0;
        byp_m      = 1'b0;
        underrun_m = 1'b0;
        used_m     = 0;
        tmo_m      = 0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        resetModel();

        // Reset values
        step = "reset";
        repeat (2) @(posedge clk);
        #1;
        checkOutput("decision_valid", 32'(decision_valid), 0);
        checkOutput("decision_allow", 32'(decision_allow), 0);
        checkOutput("cls_ready", 32'(cls_ready), 0);
        checkOutput("fifo_level", 32'(fifo_level), 0);
        checkOutput("cnt_used", cnt_used, 0);
        checkOutput("cnt_timeout", cnt_timeout, 0);
        checkOutput("err_underrun", 32'(err_underrun), 0);
        rst = 1'b0;

        // 1: three verdicts, three 4-beat packets
        step = "t1";
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("level_after_push", 32'(fifo_level), 3);
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 4; b++) begin
                applyStimulus(0, 0, 1, 1, b == 3, 0);
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("used_total", cnt_used, 3);
        checkOutput("level_drained", 32'(fifo_level), 0);

        // 2: fill to full, 9th verdict waits for the first pop
        step = "t2";
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, i[0], 0, 0, 0, 0);
        end
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 1, 0, 0);
        applyStimulus(1, 1, 1, 1, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 1, 1, 1, 0);
        checkOutput("level_refilled", 32'(fifo_level), DEPTH);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // 3: classifier late, default verdict after TMO cycles
        step = "t3";
        for (int i = 0; i < TMO - 1; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 0);
        end
        checkOutput("no_early_timeout", 32'(decision_valid), 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        tmo_m   = 1;
        fired_m = 1'b1;
        applyStimulus(1, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 1, 1, 1, 0);
        checkOutput("late_verdict_kept", 32'(fifo_level), 1);
        applyStimulus(0, 0, 1, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // 4: back-to-back single-beat packets, push every cycle
        step = "t4";
        applyStimulus(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, (i % 3) != 1, 1, 1, 1, 0);
        end
        applyStimulus(0, 0, 1, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("no_underrun", 32'(err_underrun), 0);

        // 5: reset on beat 2 of 5 with 3 verdicts queued
        step = "t5";
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 0, 0, 0, 0);
        end
        applyStimulus(0, 0, 1, 1, 0, 0);
        checkOutput("queued_before_reset", 32'(fifo_level), 3);
        cls_valid  = 1'b0;
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        mon_tlast  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_decision_valid", 32'(decision_valid), 0);
        checkOutput("rst_cls_ready", 32'(cls_ready), 0);
        checkOutput("rst_fifo_level", 32'(fifo_level), 0);
        checkOutput("rst_cnt_used", cnt_used, 0);
        checkOutput("rst_cnt_timeout", cnt_timeout, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        resetModel();
        applyStimulus(0, 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0);
        checkOutput("underrun_after_reset", 32'(err_underrun), 1);
        applyStimulus(0, 0, 1, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // 6: bypass for two packets, dropped mid-packet, then flush with push
        step = "t6";
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        cfg_bypass = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 1, 1, 1, 0);
        applyStimulus(0, 0, 1, 1, 0, 0);
        cfg_bypass = 1'b0;
        applyStimulus(0, 0, 1, 1, 1, 0);
        checkOutput("bypass_no_pop", 32'(fifo_level), 2);
        applyStimulus(0, 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 1, 1, 1, 0);
        applyStimulus(1, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("flush_level", 32'(fifo_level), 0);
        checkOutput("underrun_sticky", 32'(err_underrun), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
